// File: rtl/isa_switch_ctrl.sv
// isa_switch_ctrl: sequences an ARM <-> RISC-V mode switch.
// An accepted ISA-switch in Decode drains E/M/W, flushes the front end,
// flips the registered mode bit and redirects fetch to the captured target.
// The pipeline-control outputs are the hazard unit's requests ORed with this
// block's own requests, so both units can sit side by side.
module isa_switch_ctrl #(
  parameter logic RESET_ARM     = 1'b0,
  parameter int   DRAIN_TIMEOUT = 16,
  parameter int   CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SwitchReqD,
  input  logic             SwitchToArmD,
  input  logic [31:0]      SwitchTargetD,
  input  logic             ValidE,
  input  logic             ValidM,
  input  logic             ValidW,
  input  logic             StallF_hz,
  input  logic             StallD_hz,
  input  logic             FlushD_hz,
  input  logic             FlushE_hz,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             PCRedirect,
  output logic [31:0]      PCTarget,
  output logic             ModeArm,
  output logic             SwitchBusy,
  output logic             SwitchDone,
  output logic             SwitchAbort,
  output logic             DrainErr,
  output logic [CNT_W-1:0] SwitchCount
);

  // Drain counter only has to reach DRAIN_TIMEOUT-1.
  localparam int DCNT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_FLUSH    = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                mode_q;
  logic                to_arm_q;
  logic [31:0]         target_q;
  logic [DCNT_W-1:0]   cnt_q;
  logic                drain_err_q;
  logic [CNT_W-1:0]    sw_cnt_q;

  logic own_stall_f, own_stall_d, own_flush_d, own_flush_e;
  logic accept, abort, done, redirect, timeout;
  logic back_empty;

  assign back_empty = ~ValidE & ~ValidM & ~ValidW;

  // Next-state and this block's own pipeline requests, decoded from the state.
  always_comb begin
    state_d     = state_q;
    own_stall_f = 1'b0;
    own_stall_d = 1'b0;
    own_flush_d = 1'b0;
    own_flush_e = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    done        = 1'b0;
    redirect    = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A stalled or squashed Decode slot is not a real request yet.
        accept = SwitchReqD & ~StallD_hz & ~FlushD_hz;
        if (accept) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (FlushD_hz) begin
          // An older branch is squashing the switch: let hazard controls
          // pass through untouched and return without touching the mode.
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          own_stall_f = 1'b1;
          own_stall_d = 1'b1;
          own_flush_e = 1'b1;
          if (back_empty) begin
            state_d = S_FLUSH;
          end else if (cnt_q == DRAIN_LAST) begin
            timeout = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        own_stall_f = 1'b1;
        own_flush_d = 1'b1;
        own_flush_e = 1'b1;
        state_d     = S_REDIRECT;
      end
      S_REDIRECT: begin
        // Fetch is released to load the target; whatever it fetched in the
        // old mode is still sitting in D and must be killed.
        own_flush_d = 1'b1;
        redirect    = 1'b1;
        done        = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, captured switch, mode bit and status counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= RESET_ARM;
      to_arm_q    <= 1'b0;
      target_q    <= 32'd0;
      cnt_q       <= '0;
      drain_err_q <= 1'b0;
      sw_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        target_q <= SwitchTargetD;
        to_arm_q <= SwitchToArmD;
        cnt_q    <= '0;
      end else if (state_q == S_DRAIN) begin
        cnt_q <= cnt_q + DCNT_W'(1);
      end
      if (timeout) drain_err_q <= 1'b1;
      if (state_q == S_FLUSH) mode_q <= to_arm_q;
      if (done && (sw_cnt_q != {CNT_W{1'b1}})) sw_cnt_q <= sw_cnt_q + CNT_W'(1);
    end
  end

  // Merged pipeline controls and status outputs.
  always_comb begin
    StallF      = StallF_hz | own_stall_f;
    StallD      = StallD_hz | own_stall_d;
    FlushD      = FlushD_hz | own_flush_d;
    FlushE      = FlushE_hz | own_flush_e;
    PCRedirect  = redirect;
    PCTarget    = target_q & 32'hFFFF_FFFC;
    ModeArm     = mode_q;
    SwitchBusy  = (state_q != S_IDLE);
    SwitchDone  = done;
    SwitchAbort = abort;
    DrainErr    = drain_err_q;
    SwitchCount = sw_cnt_q;
  end

endmodule

// File: tb/tb_isa_switch_ctrl.sv
// Directed bench for isa_switch_ctrl with default parameters.
module tb_isa_switch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        SwitchReqD, SwitchToArmD;
  logic [31:0] SwitchTargetD;
  logic        ValidE, ValidM, ValidW;
  logic        StallF_hz, StallD_hz, FlushD_hz, FlushE_hz;
  logic        StallF, StallD, FlushD, FlushE;
  logic        PCRedirect;
  logic [31:0] PCTarget;
  logic        ModeArm, SwitchBusy, SwitchDone, SwitchAbort, DrainErr;
  logic [15:0] SwitchCount;

  int n_tests = 0;
  int n_fail  = 0;

  isa_switch_ctrl #(.RESET_ARM(1'b0), .DRAIN_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .SwitchReqD(SwitchReqD), .SwitchToArmD(SwitchToArmD), .SwitchTargetD(SwitchTargetD),
    .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
    .StallF_hz(StallF_hz), .StallD_hz(StallD_hz), .FlushD_hz(FlushD_hz), .FlushE_hz(FlushE_hz),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCRedirect(PCRedirect), .PCTarget(PCTarget), .ModeArm(ModeArm),
    .SwitchBusy(SwitchBusy), .SwitchDone(SwitchDone), .SwitchAbort(SwitchAbort),
    .DrainErr(DrainErr), .SwitchCount(SwitchCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; SwitchReqD = 0; SwitchToArmD = 0; SwitchTargetD = 32'h0;
    ValidE = 0; ValidM = 0; ValidW = 0;
    StallF_hz = 1; StallD_hz = 0; FlushD_hz = 0; FlushE_hz = 0;
    #3;
    n_tests++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL reset_stallf got %b exp 1", StallF); end
    n_tests++; if (ModeArm !== 1'b0) begin n_fail++; $display("FAIL reset_mode got %b exp 0", ModeArm); end
    n_tests++; if (SwitchBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", SwitchBusy); end
    n_tests++; if (PCTarget !== 32'h0) begin n_fail++; $display("FAIL reset_target got %h exp 0", PCTarget); end
    n_tests++; if (SwitchCount !== 16'd0 || DrainErr !== 1'b0) begin
      n_fail++; $display("FAIL reset_status got cnt=%0d err=%b exp 0/0", SwitchCount, DrainErr); end
    step(); step();
    rst = 1'b1; StallF_hz = 0;
    step();
  endtask

  // Drain loop: E/M/W empty out one per cycle, expect 3 DRAIN cycles.
  task automatic test_switch_to_arm();
    int n;
    SwitchReqD = 1; SwitchToArmD = 1; SwitchTargetD = 32'h0000_0103;
    ValidE = 1; ValidM = 1; ValidW = 1;
    #1;
    n_tests++; if (SwitchBusy !== 1'b0 || StallF !== 1'b0) begin
      n_fail++; $display("FAIL sw_idle got busy=%b stallf=%b exp 0/0", SwitchBusy, StallF); end
    step();
    SwitchReqD = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      {ValidE, ValidM, ValidW} = (n == 0) ? 3'b011 : (n == 1) ? 3'b001 : 3'b000;
      #1;
      if (StallD !== 1'b1) break;
      if (n == 0) begin
        n_tests++; if (StallF !== 1 || FlushE !== 1 || FlushD !== 0 || PCRedirect !== 0 || SwitchBusy !== 1) begin
          n_fail++; $display("FAIL sw_drain_ctl got F=%b E=%b D=%b R=%b B=%b exp 1 1 0 0 1",
                             StallF, FlushE, FlushD, PCRedirect, SwitchBusy); end
        n_tests++; if (PCTarget !== 32'h0000_0100) begin
          n_fail++; $display("FAIL sw_target got %h exp 00000100", PCTarget); end
      end
      n++;
      step();
    end
    n_tests++; if (n !== 3) begin n_fail++; $display("FAIL sw_drain_len got %0d exp 3", n); end
    n_tests++; if (FlushD !== 1 || StallF !== 1 || FlushE !== 1 || ModeArm !== 0) begin
      n_fail++; $display("FAIL sw_flush got D=%b F=%b E=%b mode=%b exp 1 1 1 0", FlushD, StallF, FlushE, ModeArm); end
    step(); #1;
    n_tests++; if (PCRedirect !== 1 || SwitchDone !== 1 || ModeArm !== 1 || StallF !== 0 || FlushD !== 1) begin
      n_fail++; $display("FAIL sw_redirect got R=%b done=%b mode=%b F=%b D=%b exp 1 1 1 0 1",
                         PCRedirect, SwitchDone, ModeArm, StallF, FlushD); end
    step(); #1;
    n_tests++; if (SwitchCount !== 16'd1 || SwitchBusy !== 0 || PCRedirect !== 0 || PCTarget !== 32'h100) begin
      n_fail++; $display("FAIL sw_idle_after got cnt=%0d busy=%b R=%b tgt=%h exp 1 0 0 100",
                         SwitchCount, SwitchBusy, PCRedirect, PCTarget); end
  endtask

  task automatic test_abort();
    bit saw_redirect;
    step();
    SwitchReqD = 1; SwitchToArmD = 0; SwitchTargetD = 32'h0000_0200;
    ValidE = 1; ValidM = 1; ValidW = 1;
    step();
    SwitchReqD = 0;
    #1;
    n_tests++; if (SwitchBusy !== 1 || SwitchAbort !== 0) begin
      n_fail++; $display("FAIL ab_drain1 got busy=%b abort=%b exp 1 0", SwitchBusy, SwitchAbort); end
    step();
    FlushD_hz = 1;
    #1;
    n_tests++; if (SwitchAbort !== 1 || FlushD !== 1 || PCRedirect !== 0) begin
      n_fail++; $display("FAIL ab_pulse got abort=%b D=%b R=%b exp 1 1 0", SwitchAbort, FlushD, PCRedirect); end
    step();
    FlushD_hz = 0; ValidE = 0; ValidM = 0; ValidW = 0;
    #1;
    n_tests++; if (SwitchBusy !== 0 || ModeArm !== 1 || SwitchAbort !== 0 || SwitchCount !== 16'd1) begin
      n_fail++; $display("FAIL ab_idle got busy=%b mode=%b abort=%b cnt=%0d exp 0 1 0 1",
                         SwitchBusy, ModeArm, SwitchAbort, SwitchCount); end
    saw_redirect = 0;
    for (int i = 0; i < 4; i++) begin
      if (PCRedirect === 1'b1 || SwitchBusy === 1'b1) saw_redirect = 1;
      step();
    end
    n_tests++; if (saw_redirect !== 1'b0) begin
      n_fail++; $display("FAIL ab_no_redirect got %b exp 0", saw_redirect); end
  endtask

  // Same-ISA switch with ValidM stuck high: forced advance after 16 DRAIN cycles.
  task automatic test_timeout();
    int n;
    SwitchReqD = 1; SwitchToArmD = 1; SwitchTargetD = 32'h0000_0400;
    ValidE = 0; ValidM = 1; ValidW = 0;
    step();
    SwitchReqD = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (StallD !== 1'b1) break;
      n++;
      step();
    end
    n_tests++; if (n !== 16) begin n_fail++; $display("FAIL to_drain_len got %0d exp 16", n); end
    n_tests++; if (DrainErr !== 1 || FlushD !== 1) begin
      n_fail++; $display("FAIL to_flush got err=%b D=%b exp 1 1", DrainErr, FlushD); end
    ValidM = 0;
    step(); step(); step(); #1;
    n_tests++; if (DrainErr !== 1 || SwitchCount !== 16'd2 || ModeArm !== 1 || PCTarget !== 32'h400) begin
      n_fail++; $display("FAIL to_sticky got err=%b cnt=%0d mode=%b tgt=%h exp 1 2 1 400",
                         DrainErr, SwitchCount, ModeArm, PCTarget); end
  endtask

  task automatic test_stalled_req();
    SwitchReqD = 1; SwitchToArmD = 0; SwitchTargetD = 32'h0000_0800;
    StallD_hz = 1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      n_tests++; if (SwitchBusy !== 0 || StallD !== 1) begin
        n_fail++; $display("FAIL st_hold%0d got busy=%b stalld=%b exp 0 1", i, SwitchBusy, StallD); end
    end
    StallD_hz = 0;
    step(); #1;
    n_tests++; if (SwitchBusy !== 1) begin n_fail++; $display("FAIL st_accept got busy=%b exp 1", SwitchBusy); end
    SwitchReqD = 0;
    step(); step(); step(); #1;
    n_tests++; if (SwitchBusy !== 0 || ModeArm !== 0 || SwitchCount !== 16'd3 || PCTarget !== 32'h800) begin
      n_fail++; $display("FAIL st_done got busy=%b mode=%b cnt=%0d tgt=%h exp 0 0 3 800",
                         SwitchBusy, ModeArm, SwitchCount, PCTarget); end
  endtask

  task automatic test_reset_mid();
    SwitchReqD = 1; SwitchToArmD = 1; SwitchTargetD = 32'h0000_0040;
    ValidE = 1; ValidM = 1; ValidW = 1;
    step();
    SwitchReqD = 0;
    #1;
    n_tests++; if (SwitchBusy !== 1) begin n_fail++; $display("FAIL rm_in_drain got busy=%b exp 1", SwitchBusy); end
    #1 rst = 1'b0;
    #1;
    n_tests++; if (SwitchBusy !== 0 || ModeArm !== 0 || StallF !== 0 || SwitchDone !== 0 || SwitchAbort !== 0) begin
      n_fail++; $display("FAIL rm_idle got busy=%b mode=%b F=%b done=%b abort=%b exp 0 0 0 0 0",
                         SwitchBusy, ModeArm, StallF, SwitchDone, SwitchAbort); end
    n_tests++; if (SwitchCount !== 16'd0 || PCTarget !== 32'h0 || DrainErr !== 0) begin
      n_fail++; $display("FAIL rm_status got cnt=%0d tgt=%h err=%b exp 0 0 0", SwitchCount, PCTarget, DrainErr); end
    step();
    rst = 1'b1; ValidE = 0; ValidM = 0; ValidW = 0;
    step(); #1;
    n_tests++; if (SwitchBusy !== 0 || PCRedirect !== 0) begin
      n_fail++; $display("FAIL rm_after got busy=%b R=%b exp 0 0", SwitchBusy, PCRedirect); end
  endtask

  initial begin
    test_reset();
    test_switch_to_arm();
    test_abort();
    test_timeout();
    test_stalled_req();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
